line_buffer_3row: RTL and testbench
===================================

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter PIC_WIDTH, default 250: pixels per image row.
REQ-002 Parameter PIC_HEIGHT, default 250: rows per frame.
REQ-003 Parameter WIDTH, default 24: pixel data width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 frame_start  input  1  single-cycle pulse; next accepted pixel is row 0, column 0.
REQ-007 valid_in  input  1  din holds a valid raster-order pixel this cycle.
REQ-008 din  input  WIDTH  input pixel.
REQ-009 valid_out  output  1  dout1..dout3 hold a valid vertical 3-pixel column.
REQ-010 dout1  output  WIDTH  pixel from row r-2, same column.
REQ-011 dout2  output  WIDTH  pixel from row r-1, same column.
REQ-012 dout3  output  WIDTH  pixel from current row r.
REQ-013 frame_done  output  1  single-cycle pulse after the last pixel of a frame.

Function
REQ-014 The block SHALL keep a column counter col (0..PIC_WIDTH-1) and a row counter row (0..PIC_HEIGHT-1), both advancing only on valid_in.
REQ-015 col SHALL increment per accepted pixel and wrap to 0 after PIC_WIDTH-1, incrementing row on wrap.
REQ-016 row SHALL wrap to 0 after the last pixel of row PIC_HEIGHT-1; frame_done SHALL pulse high the following cycle.
REQ-017 Two line memories, each PIC_WIDTH x WIDTH, SHALL be addressed by col: lineA holds row r-1, lineB holds row r-2.
REQ-018 On an accepted pixel: dout3<=din, dout2<=lineA[col], dout1<=lineB[col], lineA[col]<=din, lineB[col]<=lineA[col] (read-before-write, same address).
REQ-019 Latency SHALL be exactly 1 cycle from din accepted to dout3 showing it.
REQ-020 valid_out SHALL be registered: high the cycle after an accepted pixel with row>=2, else low.
REQ-021 With valid_in low, dout1..dout3 SHALL hold value, valid_out SHALL be low, counters and memories unchanged.
REQ-022 Gaps in valid_in mid-row SHALL NOT disturb column/row alignment.
REQ-023 frame_start SHALL clear col and row synchronously; if coincident with valid_in, that pixel SHALL be treated as row 0, column 0.
REQ-024 frame_start SHALL NOT clear line memories; rows 0 and 1 of a new frame never assert valid_out, so stale data is never qualified.
REQ-025 frame_start mid-frame SHALL abort the frame without a frame_done pulse.
REQ-026 Output stream per row SHALL be PIC_WIDTH contiguous-in-order valid_out beats, matching a downstream 3x3 window stage that counts columns per valid run.

Reset
REQ-027 On rst_n low: col=0, row=0, valid_out=0, frame_done=0, dout1=dout2=dout3=0.
REQ-028 Line memory contents SHALL be undefined after reset and need no reset logic.
REQ-029 Reset asserted mid-frame SHALL abort the frame; first pixel after release is row 0, column 0.

Structure
REQ-030 Default PIC_WIDTH, PIC_HEIGHT, WIDTH and counter widths (clog2 of PIC_WIDTH/PIC_HEIGHT) SHALL live in the shared image-pipeline package.
REQ-031 One sub-module line_ram (single clock, one address, synchronous read-before-write, depth/width parameterised) SHALL be instantiated twice; it SHALL infer block RAM.
REQ-032 Counters, output registers and valid/frame_done logic SHALL reside in line_buffer_3row.

Verification (PIC_WIDTH=4, PIC_HEIGHT=4, din=16*row+col)
REQ-033 Continuous frame, valid_in high 16 cycles -> valid_out low first 8 beats; then 8 beats (dout1,dout2,dout3) = (0x00,0x10,0x20),(0x01,0x11,0x21)...(0x13,0x23,0x33).
REQ-034 Same frame with valid_in low every other cycle -> identical output sequence, valid_out only after accepted pixels, outputs hold during gaps.
REQ-035 Last pixel 0x33 accepted -> frame_done high exactly one cycle later; second frame restarts with 8 invalid beats.
REQ-036 frame_start pulsed after 6 pixels, then full frame -> no frame_done for aborted frame; outputs match REQ-033 sequence.
REQ-037 frame_start coincident with valid_in and din=0x00 -> treated as row 0 col 0; full sequence correct.
REQ-038 rst_n low for 2 cycles at pixel 10 -> all outputs 0 immediately; after release, next frame matches REQ-033.

Source files
------------

// File: rtl/line_buffer_3row_pkg.sv
// Shared image-pipeline defaults: frame geometry, pixel width and counter sizing.
package line_buffer_3row_pkg;

    localparam int unsigned LB_PIC_WIDTH  = 250;
    localparam int unsigned LB_PIC_HEIGHT = 250;
    localparam int unsigned LB_WIDTH      = 24;

    // Counter width able to index 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned LB_COL_W = cnt_width(LB_PIC_WIDTH);
    localparam int unsigned LB_ROW_W = cnt_width(LB_PIC_HEIGHT);

endpackage

// File: rtl/line_buffer_3row_ram.sv
// Single-port line memory: one address, synchronous read-before-write, no reset on storage.
module line_ram
    import line_buffer_3row_pkg::*;
#(
    parameter int unsigned DEPTH = LB_PIC_WIDTH,
    parameter int unsigned WIDTH = LB_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [cnt_width(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: emits a vertical column (r-2, r-1, r) per accepted pixel once row >= 2.
module line_buffer_3row
    import line_buffer_3row_pkg::*;
#(
    parameter int unsigned PIC_WIDTH  = LB_PIC_WIDTH,
    parameter int unsigned PIC_HEIGHT = LB_PIC_HEIGHT,
    parameter int unsigned WIDTH      = LB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             frame_done
);

    localparam int unsigned COL_W = cnt_width(PIC_WIDTH);
    localparam int unsigned ROW_W = cnt_width(PIC_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIC_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic [WIDTH-1:0] dout3_q, dout3_d;
    logic             parity_q, parity_d;
    logic             rd_ok_q, rd_ok_d;
    logic             valid_out_q, valid_out_d;
    logic             frame_done_q, frame_done_d;
    logic [WIDTH-1:0] rd_even, rd_odd;

    always_comb begin
        col_cur      = frame_start ? '0 : col_q;
        row_cur      = frame_start ? '0 : row_q;
        col_d        = col_cur;
        row_d        = row_cur;
        dout3_d      = dout3_q;
        parity_d     = parity_q;
        rd_ok_d      = rd_ok_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        if (valid_in) begin
            dout3_d     = din;
            parity_d    = row_cur[0];
            rd_ok_d     = 1'b1;
            valid_out_d = (32'(row_cur) >= 32'd2);
            if (col_cur == COL_LAST) begin
                col_d = '0;
                if (row_cur == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_cur + ROW_W'(1);
                end
            end else begin
                col_d = col_cur + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            dout3_q      <= '0;
            parity_q     <= 1'b0;
            rd_ok_q      <= 1'b0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            dout3_q      <= dout3_d;
            parity_q     <= parity_d;
            rd_ok_q      <= rd_ok_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Rows ping-pong between two memories by row parity instead of copying lineA into lineB:
    // the memory written this row returns row r-2 (read-before-write), the other returns r-1.
    line_ram #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH)
    ) u_line_even (
        .clk_i   (clk),
        .en_i    (valid_in),
        .we_i    (valid_in & ~row_cur[0]),
        .addr_i  (col_cur),
        .wdata_i (din),
        .rdata_o (rd_even)
    );

    line_ram #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH)
    ) u_line_odd (
        .clk_i   (clk),
        .en_i    (valid_in),
        .we_i    (valid_in & row_cur[0]),
        .addr_i  (col_cur),
        .wdata_i (din),
        .rdata_o (rd_odd)
    );

    // RAM read registers carry no reset, so force zero until the first pixel after reset.
    assign dout1      = rd_ok_q ? (parity_q ? rd_odd  : rd_even) : '0;
    assign dout2      = rd_ok_q ? (parity_q ? rd_even : rd_odd)  : '0;
    assign dout3      = dout3_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row at 4x4 frames with din = 16*row + col.
module tb_line_buffer_3row;

    localparam int unsigned PW = 4;
    localparam int unsigned PH = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          valid_in;
    logic [DW-1:0] din;
    logic          valid_out;
    logic [DW-1:0] dout1, dout2, dout3;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench position model and last qualified column, used to check holds during gaps.
    int            mr = 0;
    int            mc = 0;
    logic [DW-1:0] h1 = '0, h2 = '0, h3 = '0;
    bit            hv = 1'b0;

    always #5 clk = ~clk;

    line_buffer_3row #(
        .PIC_WIDTH  (PW),
        .PIC_HEIGHT (PH),
        .WIDTH      (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .valid_in    (valid_in),
        .din         (din),
        .valid_out   (valid_out),
        .dout1       (dout1),
        .dout2       (dout2),
        .dout3       (dout3),
        .frame_done  (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (row %0d col %0d)", tag, got, exp, mr, mc);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid_out"}, 32'(valid_out), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_dout1"}, 32'(dout1), 32'd0);
        check_eq({tag, "_dout2"}, 32'(dout2), 32'd0);
        check_eq({tag, "_dout3"}, 32'(dout3), 32'd0);
    endtask

    // One clock: optional frame_start, optional pixel (value taken from the model position).
    task automatic step(input bit fs, input bit v);
        int r, c;
        logic [DW-1:0] d;
        if (fs) begin
            mr = 0;
            mc = 0;
        end
        r = mr;
        c = mc;
        d = DW'(16 * r + c);
        frame_start = fs;
        valid_in    = v;
        din         = v ? d : 8'hEE;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        valid_in    = 1'b0;
        if (v) begin
            check_eq("dout3", 32'(dout3), 32'(d));
            check_eq("valid_out", 32'(valid_out), (r >= 2) ? 32'd1 : 32'd0);
            check_eq("frame_done", 32'(frame_done),
                     (r == int'(PH) - 1 && c == int'(PW) - 1) ? 32'd1 : 32'd0);
            if (r >= 2) begin
                check_eq("dout2", 32'(dout2), 32'(16 * (r - 1) + c));
                check_eq("dout1", 32'(dout1), 32'(16 * (r - 2) + c));
                h1 = DW'(16 * (r - 2) + c);
                h2 = DW'(16 * (r - 1) + c);
            end
            hv = (r >= 2);
            h3 = d;
            mc++;
            if (mc == int'(PW)) begin
                mc = 0;
                mr = (mr == int'(PH) - 1) ? 0 : mr + 1;
            end
        end else begin
            check_eq("gap_valid_out", 32'(valid_out), 32'd0);
            check_eq("gap_frame_done", 32'(frame_done), 32'd0);
            check_eq("gap_dout3", 32'(dout3), 32'(h3));
            if (hv) begin
                check_eq("gap_dout2", 32'(dout2), 32'(h2));
                check_eq("gap_dout1", 32'(dout1), 32'(h1));
            end
        end
    endtask

    task automatic run_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        valid_in    = 1'b0;
        din         = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous frame, then the same frame with a gap before every pixel.
        run_pixels(16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);

        // Abort after 6 pixels with a standalone frame_start, then a clean frame.
        run_pixels(6);
        step(1'b1, 1'b0);
        run_pixels(16);

        // frame_start coincident with the first pixel of a frame.
        run_pixels(5);
        step(1'b1, 1'b1);
        run_pixels(15);

        // Asynchronous reset mid-frame after 10 pixels.
        run_pixels(10);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
        h3 = '0;
        hv = 1'b0;
        step(1'b0, 1'b0);
        run_pixels(16);
        step(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
